// File: rtl/dec_unbinder_seq.sv
// Sequential hypervector unbinder: rotates a bound query right per feature and
// scans item memory for the level with the largest overlap.
module dec_unbinder_seq #(
    parameter int HV_DIM     = 1024,
    parameter int FEATURES   = 8,
    parameter int LEVELS     = 16,
    parameter int SHIFT_BASE = 496
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [HV_DIM-1:0]             in_hv,
    output logic                          lvl_rd_en,
    output logic [$clog2(LEVELS)-1:0]     lvl_addr,
    input  logic [HV_DIM-1:0]             lvl_hv,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FEATURES)-1:0]   out_feat,
    output logic [$clog2(LEVELS)-1:0]     out_level,
    output logic [$clog2(HV_DIM+1)-1:0]   out_score,
    output logic                          out_last
);

    localparam int FW = $clog2(FEATURES);
    localparam int LW = $clog2(LEVELS);
    localparam int SW = $clog2(HV_DIM + 1);
    localparam int KW = $clog2(LEVELS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        SCAN = 2'd2,
        EMIT = 2'd3
    } state_t;

    // Shared rotation table used by the encoder; entries 496/497 are the
    // shifts of the first two features in the default configuration.
    function automatic int shift_tab(input int idx);
        case (idx)
            496:     return 3;
            497:     return 5;
            default: return (idx * 389 + 17) % 4096;
        endcase
    endfunction

    function automatic logic [HV_DIM-1:0] rot_right(input logic [HV_DIM-1:0] v,
                                                    input int s);
        logic [2*HV_DIM-1:0] d;
        d = {v, v} >> s;
        return d[HV_DIM-1:0];
    endfunction

    function automatic logic [SW-1:0] popcount(input logic [HV_DIM-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < HV_DIM; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    state_t              state, state_n;
    logic [FW-1:0]       feat;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_m1;
    logic [SW-1:0]       best_score;
    logic [LW-1:0]       best_level;
    logic [HV_DIM-1:0]   query_hv;
    logic [HV_DIM-1:0]   unbound;
    logic [HV_DIM-1:0]   rot_hv;
    logic [SW-1:0]       score;
    logic                last_feat;

    assign last_feat = (int'(feat) == FEATURES - 1);
    assign score     = popcount(unbound & lvl_hv);
    assign k_m1      = k - KW'(1);

    always_comb begin
        rot_hv = '0;
        for (int j = 0; j < FEATURES; j++)
            if (int'(feat) == j) rot_hv = rot_right(query_hv, shift_tab(SHIFT_BASE + j) % HV_DIM);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        lvl_rd_en = 1'b0;
        lvl_addr  = '0;
        out_valid = 1'b0;
        out_feat  = '0;
        out_level = '0;
        out_score = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ROT;
            end
            ROT: state_n = SCAN;
            SCAN: begin
                // Reads lead scoring by one cycle: cycle k reads level k, scores level k-1.
                if (k < KW'(LEVELS)) begin
                    lvl_rd_en = 1'b1;
                    lvl_addr  = k[LW-1:0];
                end
                if (k == KW'(LEVELS)) state_n = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_feat  = feat;
                out_level = best_level;
                out_score = best_score;
                out_last  = last_feat;
                if (out_ready) state_n = last_feat ? IDLE : ROT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feat       <= '0;
            k          <= '0;
            best_score <= '0;
            best_level <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) feat <= '0;
                ROT: begin
                    k          <= '0;
                    best_score <= '0;
                    best_level <= '0;
                end
                SCAN: begin
                    k <= k + KW'(1);
                    // Strictly greater keeps the lowest level index on ties.
                    if (k != '0 && score > best_score) begin
                        best_score <= score;
                        best_level <= k_m1[LW-1:0];
                    end
                end
                EMIT: if (out_ready && !last_feat) feat <= feat + FW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) query_hv <= in_hv;
        if (state == ROT)              unbound  <= rot_hv;
    end

endmodule

// File: doc/dec_unbinder_seq.md
DEC_UNBINDER_SEQ -- requirements
Module: dec_unbinder_seq

Interface
REQ-001 SHALL have parameter HV_DIM, default from the codebase package, hypervector width in bits.
REQ-002 SHALL have parameter FEATURES, default 8, number of features decoded per query.
REQ-003 SHALL have parameter LEVELS, default 16, number of level hypervectors in item memory.
REQ-004 SHALL have parameter SHIFT_BASE, default 496, first index into the package SHIFTS table; feature f uses SHIFTS[SHIFT_BASE+f].
REQ-005 SHALL use one clock, clk, with a synchronous active-high reset, rst; all state changes on rising clk.
REQ-006 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  query hypervector valid
- in_ready  out  1  block accepts a query
- in_hv  in  HV_DIM  bound query hypervector
- lvl_rd_en  out  1  item-memory read strobe
- lvl_addr  out  $clog2(LEVELS)  item-memory level address
- lvl_hv  in  HV_DIM  item-memory read data, valid 1 cycle after the strobe
- out_valid  out  1  decode result valid
- out_ready  in  1  consumer accepts the result
- out_feat  out  $clog2(FEATURES)  feature index
- out_level  out  $clog2(LEVELS)  best-matching level
- out_score  out  $clog2(HV_DIM+1)  best overlap count
- out_last  out  1  result is for feature FEATURES-1

Function
REQ-007 The encoder binds by rotating left by S. Unbinding SHALL rotate in_hv right by S, with S = SHIFTS[SHIFT_BASE+f] mod HV_DIM, bit i of the result = bit (i+S) mod HV_DIM of the query.
REQ-008 States SHALL be IDLE, ROT, SCAN and EMIT; in_ready SHALL be 1 only in IDLE.
REQ-009 IDLE: on in_valid & in_ready the block SHALL latch in_hv, clear the feature counter f to 0 and go to ROT.
REQ-010 ROT (1 cycle): the block SHALL register the unbound vector for feature f, clear best_score and best_level to 0, clear the level counter and go to SCAN.
REQ-011 SCAN SHALL last exactly LEVELS+1 cycles. In cycle k (k<LEVELS) lvl_rd_en=1 and lvl_addr=k. In cycle k (k≥1) the block SHALL score level k-1 as popcount(unbound & lvl_hv).
REQ-012 best_score and best_level SHALL update only when the score is strictly greater than best_score, so ties keep the lowest level index. After the last score the block SHALL go to EMIT.
REQ-013 EMIT SHALL drive out_valid=1 with out_feat=f, out_level=best_level and out_score=best_score; out_last=1 iff f=FEATURES-1. The outputs SHALL stay stable until out_ready.
REQ-014 On out_valid & out_ready in EMIT:
- if f<FEATURES-1: f+1, go to ROT;
- else go to IDLE.
REQ-015 Per-feature latency from ROT entry to the first out_valid SHALL be LEVELS+2 cycles. With out_ready held at 1, a query SHALL take FEATURES*(LEVELS+3) cycles after acceptance.
REQ-016 An all-zero overlap for every level SHALL report level 0 with score 0.
REQ-017 lvl_rd_en SHALL be 0 outside the first LEVELS cycles of SCAN. lvl_hv SHALL be ignored except in SCAN cycles 1..LEVELS.
REQ-018 in_hv and in_valid SHALL be ignored outside IDLE; a new query SHALL NOT be accepted before the last result handshake.

Reset
REQ-019 While rst=1 the block SHALL enter IDLE and drive the following outputs to 0: out_valid, out_feat, out_level, out_score, out_last, lvl_rd_en and lvl_addr. Counters and best registers SHALL also clear.
REQ-020 Reset asserted in any state, including mid-SCAN or EMIT with out_valid high, SHALL abort the query with no further output. in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
All scenarios use HV_DIM=16, FEATURES=2, LEVELS=4, SHIFTS[SHIFT_BASE]=3, SHIFTS[SHIFT_BASE+1]=5, and level memory L0=0x0003, L1=0x00F0, L2=0x000F, L3=0xF000.
REQ-021 Query in_hv=0x0078 (L2 rotated left by 3), out_ready=1:
- feature 0 -> out_level=2, out_score=4, out_last=0, out_valid high 6 cycles after acceptance;
- feature 1 -> out_last=1, then in_ready=1.
REQ-022 Tie: unbound vector 0x00FF for feature 0 -> overlaps L0=2, L1=4, L2=4 -> out_level=1, out_score=4 (lowest index wins).
REQ-023 Query in_hv=0x0000 -> both features report out_level=0, out_score=0.
REQ-024 Backpressure: out_ready=0 for 5 cycles during EMIT -> out_valid and all out_* fields stable, no lvl_rd_en, state unchanged; the first cycle with out_ready=1 completes the handshake.
REQ-025 Reset asserted at SCAN cycle 2, then released -> all outputs 0 and in_ready=1 the next cycle; a fresh query then decodes exactly as in REQ-021.
REQ-026 in_valid pulsed during SCAN -> ignored, and no second query is started.
